// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int NREG       = 8;
  localparam int DATA_W     = 32;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/regfile_addr_decode.sv
// One-hot register select decode; addresses with no matching register give all zero.
module regfile_addr_decode
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int N_OUT  = NREG
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_OUT-1:0]  sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sel[i] = (int'(addr) == i);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter into a register file, round-robin on ties.
// Define REGFILE_WB_FIXED_PRIO_EN to make requester A always win ties instead.
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREG   = regfile_pkg::NREG
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Stall,
  input  logic                              A_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] A_addr,
  input  logic [DATA_W-1:0]                 A_data,
  output logic                              A_ready,
  input  logic                              B_valid,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] B_addr,
  input  logic [DATA_W-1:0]                 B_data,
  output logic                              B_ready,
  output logic                              BE,
  output logic [NREG-1:0]                   RE,
  output logic [DATA_W-1:0]                 wr_data,
  output logic                              Conflict
);

  import regfile_pkg::*;

  logic                  grant_a;
  logic                  grant_b;
  logic                  hs_p0;
  logic                  conflict_p0;
  logic [REG_ADDR_W-1:0] sel_addr_p0;
  logic [DATA_W-1:0]     sel_data_p0;
  logic [NREG-1:0]       sel_onehot_p0;

`ifndef REGFILE_WB_FIXED_PRIO_EN
  grant_t last_grant;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_grant <= GNT_B;
    end else if (grant_a) begin
      last_grant <= GNT_A;
    end else if (grant_b) begin
      last_grant <= GNT_B;
    end
  end
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!Rst && !Stall) begin
`ifdef REGFILE_WB_FIXED_PRIO_EN
      grant_a = A_valid;
      grant_b = B_valid && !A_valid;
`else
      grant_a = A_valid && (!B_valid || (last_grant == GNT_B));
      grant_b = B_valid && (!A_valid || (last_grant == GNT_A));
`endif
    end
  end

  assign A_ready     = grant_a;
  assign B_ready     = grant_b;
  assign hs_p0       = grant_a || grant_b;
  assign sel_addr_p0 = grant_b ? B_addr : A_addr;
  assign sel_data_p0 = grant_b ? B_data : A_data;
  assign conflict_p0 = hs_p0 && A_valid && B_valid && (A_addr == B_addr);

  regfile_addr_decode #(
    .ADDR_W (REG_ADDR_W),
    .N_OUT  (NREG)
  ) u_decode (
    .addr (sel_addr_p0),
    .sel  (sel_onehot_p0)
  );

  // Stage p0 -> output: register-only outputs, one write per accepted handshake
  always_ff @(posedge Clk) begin
    if (Rst) begin
      BE       <= 1'b0;
      RE       <= '0;
      wr_data  <= '0;
      Conflict <= 1'b0;
    end else begin
      BE       <= hs_p0;
      RE       <= hs_p0 ? sel_onehot_p0 : '0;
      Conflict <= conflict_p0;
      if (hs_p0) begin
        wr_data <= sel_data_p0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; honours REGFILE_WB_FIXED_PRIO_EN for tie expectations.
module tb_regfile_wb_arbiter;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        A_valid;
  logic [2:0]  A_addr;
  logic [31:0] A_data;
  logic        A_ready;
  logic        B_valid;
  logic [2:0]  B_addr;
  logic [31:0] B_data;
  logic        B_ready;
  logic        BE;
  logic [7:0]  RE;
  logic [31:0] wr_data;
  logic        Conflict;

  typedef struct {
    logic [7:0]  re;
    logic [31:0] data;
    logic        conf;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  regfile_wb_arbiter #(
    .DATA_W (32),
    .NREG   (8)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Stall    (Stall),
    .A_valid  (A_valid),
    .A_addr   (A_addr),
    .A_data   (A_data),
    .A_ready  (A_ready),
    .B_valid  (B_valid),
    .B_addr   (B_addr),
    .B_data   (B_data),
    .B_ready  (B_ready),
    .BE       (BE),
    .RE       (RE),
    .wr_data  (wr_data),
    .Conflict (Conflict)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] re, input logic [31:0] data, input logic conf);
    wr_t w;
    w.re   = re;
    w.data = data;
    w.conf = conf;
    exp_q.push_back(w);
  endtask

  // Monitor: every presented write must match the oldest expected write
  initial begin : monitor
    wr_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (BE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got RE=%b data=%h, required no write", RE, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_re", 32'(RE), 32'(e.re));
          chk("wr_data", wr_data, e.data);
          chk("wr_conflict", 32'(Conflict), 32'(e.conf));
        end
      end
    end
  end

  initial begin : driver
    logic exp_a;
    Rst = 1'b1; Stall = 1'b0;
    A_valid = 1'b0; A_addr = '0; A_data = '0;
    B_valid = 1'b0; B_addr = '0; B_data = '0;

    repeat (2) @(negedge Clk);
    #1;
    chk("rst_be", 32'(BE), 32'd0);
    chk("rst_re", 32'(RE), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_conflict", 32'(Conflict), 32'd0);

    // Request during reset stays pending, then single A write
    A_valid = 1'b1; A_addr = 3'd5; A_data = 32'hDEADBEEF;
    #1 chk("rst_a_ready", 32'(A_ready), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1 chk("single_a_ready", 32'(A_ready), 32'd1);
    push(8'b0010_0000, 32'hDEADBEEF, 1'b0);
    @(negedge Clk);
    A_valid = 1'b0;
    @(negedge Clk);
    #1;
    chk("idle_be", 32'(BE), 32'd0);
    chk("idle_re", 32'(RE), 32'd0);
    chk("idle_wr_data_hold", wr_data, 32'hDEADBEEF);

    // Fresh reset so A wins the first tie, then four back-to-back ties
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    A_valid = 1'b1; A_addr = 3'd1; A_data = 32'h11;
    B_valid = 1'b1; B_addr = 3'd2; B_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef REGFILE_WB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (k % 2 == 0);
`endif
      chk("tie_a_ready", 32'(A_ready), 32'(exp_a));
      chk("tie_b_ready", 32'(B_ready), 32'(!exp_a));
      if (exp_a) push(8'b0000_0010, 32'h11, 1'b0);
      else       push(8'b0000_0100, 32'h22, 1'b0);
      if (k > 0) chk("tie_be_stream", 32'(BE), 32'd1);
      @(negedge Clk);
    end
    A_valid = 1'b0; B_valid = 1'b0;
    #1 chk("tie_be_last", 32'(BE), 32'd1);

    // Same-address collision: A first with Conflict, then B lands last
    @(negedge Clk);
    A_valid = 1'b1; A_addr = 3'd3; A_data = 32'd1;
    B_valid = 1'b1; B_addr = 3'd3; B_data = 32'd2;
    #1;
    chk("coll_a_ready", 32'(A_ready), 32'd1);
    chk("coll_b_ready0", 32'(B_ready), 32'd0);
    push(8'b0000_1000, 32'd1, 1'b1);
    @(negedge Clk);
    A_valid = 1'b0;
    #1 chk("coll_b_ready1", 32'(B_ready), 32'd1);
    push(8'b0000_1000, 32'd2, 1'b0);
    @(negedge Clk);
    B_valid = 1'b0;
    @(negedge Clk);
    #1;
    chk("coll_final_data", wr_data, 32'd2);
    chk("coll_conflict_clear", 32'(Conflict), 32'd0);

    // Stall holds A off for three cycles
    Stall = 1'b1;
    A_valid = 1'b1; A_addr = 3'd6; A_data = 32'h66;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_a_ready", 32'(A_ready), 32'd0);
      chk("stall_be", 32'(BE), 32'd0);
      @(negedge Clk);
    end
    Stall = 1'b0;
    #1 chk("unstall_a_ready", 32'(A_ready), 32'd1);
    push(8'b0100_0000, 32'h66, 1'b0);
    @(negedge Clk);
    A_valid = 1'b0;
    #1 chk("unstall_be", 32'(BE), 32'd1);

    // Reset while a write sits in the output stage, B pending across it
    @(negedge Clk);
    A_valid = 1'b1; A_addr = 3'd0; A_data = 32'hA0;
    #1 chk("pre_rst_a_ready", 32'(A_ready), 32'd1);
    push(8'b0000_0001, 32'hA0, 1'b0);
    @(negedge Clk);
    A_valid = 1'b0;
    B_valid = 1'b1; B_addr = 3'd7; B_data = 32'hB7;
    Rst = 1'b1;
    #1;
    chk("rst_mid_be", 32'(BE), 32'd1);
    chk("rst_b_ready", 32'(B_ready), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("post_rst_be", 32'(BE), 32'd0);
    chk("post_rst_re", 32'(RE), 32'd0);
    chk("post_rst_wr_data", wr_data, 32'd0);
    chk("post_rst_b_ready", 32'(B_ready), 32'd1);
    push(8'b1000_0000, 32'hB7, 1'b0);
    @(negedge Clk);
    B_valid = 1'b0;
    #1 chk("post_rst_b_write", 32'(BE), 32'd1);

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
